// File: rtl/halt_pkg.sv
// Shared types for the CPU halt/wake controller: FSM states and wake cause codes.
package halt_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StWake   = 2'd2
  } halt_state_e;

  typedef enum logic [1:0] {
    WakeNone  = 2'd0,
    WakeGamma = 2'd1,
    WakeKey   = 2'd2
  } wake_cause_e;

endpackage

// File: rtl/key_debounce.sv
// Counts consecutive 64 Hz rising edges with a key held; key_ok once the count saturates.
module key_debounce #(
  parameter int unsigned K_WIDTH        = 4,
  parameter int unsigned DEBOUNCE_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               start,
  input  logic               sample_en,
  input  logic               tap,
  input  logic [K_WIDTH-1:0] k_in,
  output logic               key_ok
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS);

  logic            tap_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise;

  assign rise = tap & ~tap_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (sample_en && rise) begin
      if (|k_in) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // The edge register tracks the tap in every state so the first halted edge is genuine.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tap_q <= 1'b0;
      cnt_q <= '0;
    end else if (clk_en) begin
      tap_q <= tap;
      cnt_q <= cnt_d;
    end
  end

  assign key_ok = (cnt_q == CntMax);

endmodule

// File: rtl/halt_wake_ctrl.sv
// Halt/wake control for the CPU: divider clear requests, HLT entry, gamma or key wake-up.
module halt_wake_ctrl
  import halt_pkg::*;
#(
  parameter int unsigned K_WIDTH        = 4,
  parameter int unsigned DEBOUNCE_TICKS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               halt_req,
  input  logic               idiv_req,
  input  logic               gamma_clr_req,
  input  logic               gamma,
  input  logic               divider_64hz,
  input  logic [K_WIDTH-1:0] k_in,
  output logic               reset_gamma,
  output logic               reset_divider,
  output logic               cpu_halted,
  output logic               wake_pulse,
  output logic [1:0]         wake_cause
);

  halt_state_e state_q, state_d;
  wake_cause_e cause_q, cause_d;
  logic        rg_q, rg_d;
  logic        rd_q, rd_d;
  logic        halted_q, pulse_q;
  logic        start;
  logic        key_ok;

  key_debounce #(
    .K_WIDTH       (K_WIDTH),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_key_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .start    (start),
    .sample_en(state_q == StHalted),
    .tap      (divider_64hz),
    .k_in     (k_in),
    .key_ok   (key_ok)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    rg_d    = 1'b0;
    rd_d    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      StRun: begin
        rd_d = idiv_req;
        rg_d = gamma_clr_req;
        if (halt_req) begin
          state_d = StHalted;
          cause_d = WakeNone;
          start   = 1'b1;
        end
      end
      StHalted: begin
        // Gamma wins over a key that debounces in the same cycle.
        if (gamma) begin
          state_d = StWake;
          cause_d = WakeGamma;
        end else if (key_ok) begin
          state_d = StWake;
          cause_d = WakeKey;
        end
      end
      StWake:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StRun;
      cause_q  <= WakeNone;
      rg_q     <= 1'b0;
      rd_q     <= 1'b0;
      halted_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      rg_q     <= rg_d;
      rd_q     <= rd_d;
      halted_q <= (state_d != StRun);
      pulse_q  <= (state_d == StWake);
    end
  end

  assign reset_gamma   = rg_q;
  assign reset_divider = rd_q;
  assign cpu_halted    = halted_q;
  assign wake_pulse    = pulse_q;
  assign wake_cause    = cause_q;

endmodule
